// File: rtl/rv32_multicycle_sequencer_if.sv
// Instruction and data memory request/ready handshakes between the sequencer and the memories.
interface rv32_multicycle_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/rv32_multicycle_sequencer.sv
// Control FSM for a multi-cycle RV32I core: fetch/decode/exec/mem/writeback sequencing,
// memory handshakes with a timeout watchdog, and a retired-instruction counter.
module rv32_multicycle_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  rv32_multicycle_sequencer_if.master         mem,
  output logic                                ir_we,
  input  logic                                reg_write,
  input  logic [1:0]                          mem_store,
  input  logic [2:0]                          mem_load,
  input  logic [1:0]                          jump_code,
  input  logic                                branch_taken,
  input  logic                                illegal,
  output logic                                pc_we,
  output logic [1:0]                          pc_sel,
  output logic                                rf_we,
  output logic [1:0]                          wb_sel,
  output logic [31:0]                         pc_init,
  output logic                                halted,
  output logic [2:0]                          state,
  output logic [31:0]                         instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q;
  logic        is_mem;
  logic [1:0]  wb_sel_dec;
  logic [1:0]  pc_sel_dec;

  assign is_mem = (mem_load != 3'b000) || (mem_store != 2'b00);

  // Writeback source is decoded once and shared by MEM (so load data settles) and WB.
  always_comb begin
    wb_sel_dec = 2'b00;
    if (mem_load != 3'b000)   wb_sel_dec = 2'b01;
    else if (jump_code[1])    wb_sel_dec = 2'b10;
  end

  always_comb begin
    pc_sel_dec = 2'b00;
    case (jump_code)
      2'b10:   pc_sel_dec = 2'b01;
      2'b11:   pc_sel_dec = 2'b10;
      2'b01:   pc_sel_dec = branch_taken ? 2'b01 : 2'b00;
      default: pc_sel_dec = 2'b00;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d      = state_q;
    wait_d       = wait_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    halted       = 1'b0;

    // State already reads FETCH during reset; gating on !rst keeps every request and enable low.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem.imem_req = 1'b1;
          if (mem.imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
        S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = (mem_store != 2'b00);
          wb_sel       = wb_sel_dec;
          if (mem.dmem_ready) begin
            state_d = S_WB;
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        S_WB: begin
          pc_we   = 1'b1;
          rf_we   = reg_write && (mem_store == 2'b00);
          pc_sel  = pc_sel_dec;
          wb_sel  = wb_sel_dec;
          state_d = S_FETCH;
        end
        S_HALT:  halted  = 1'b1;
        default: state_d = S_HALT;
      endcase
    end

    // The watchdog measures one wait at a time, so any state change restarts it.
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_WB) instret_q <= instret_q + 32'd1;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign pc_init = RESET_PC;

endmodule

// File: tb/tb_rv32_multicycle_sequencer.sv
// Directed bench for rv32_multicycle_sequencer: per-cycle output vectors checked against hand-derived values.
module tb_rv32_multicycle_sequencer;

  logic        clk;
  logic        rst;
  logic        ir_we, pc_we, rf_we, halted;
  logic        reg_write, branch_taken, illegal;
  logic [1:0]  mem_store, jump_code, pc_sel, wb_sel;
  logic [2:0]  mem_load, dut_state;
  logic [31:0] pc_init, instret;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_instret = 32'd0;

  logic [13:0] got   [0:31];
  logic [31:0] got_ir[0:31];
  logic [13:0] exp_v [0:31];

  rv32_multicycle_sequencer_if bus ();

  rv32_multicycle_sequencer #(
    .RESET_PC    (32'h0000_1000),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (bus),
    .ir_we        (ir_we),
    .reg_write    (reg_write),
    .mem_store    (mem_store),
    .mem_load     (mem_load),
    .jump_code    (jump_code),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .pc_init      (pc_init),
    .halted       (halted),
    .state        (dut_state),
    .instret      (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Vector layout: {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, wb_sel, halted}
  function automatic logic [13:0] obs();
    return {dut_state, bus.imem_req, ir_we, bus.dmem_req, bus.dmem_we, pc_we, pc_sel, rf_we, wb_sel, halted};
  endfunction

  function automatic logic [13:0] e_fetch(input logic irw);
    return {3'd0, 1'b1, irw, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
  endfunction

  function automatic logic [13:0] e_idle(input logic [2:0] st);
    return {st, 11'b0};
  endfunction

  function automatic logic [13:0] e_mem(input logic we, input logic [1:0] ws);
    return {3'd3, 1'b0, 1'b0, 1'b1, we, 1'b0, 2'b00, 1'b0, ws, 1'b0};
  endfunction

  function automatic logic [13:0] e_wb(input logic [1:0] ps, input logic rw, input logic [1:0] ws);
    return {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ps, rw, ws, 1'b0};
  endfunction

  function automatic logic [13:0] e_halt();
    return {3'd5, 10'b0, 1'b1};
  endfunction

  task automatic set_dec(input logic rw, input logic [1:0] ms, input logic [2:0] ml,
                         input logic [1:0] jc, input logic bt, input logic il);
    reg_write    = rw;
    mem_store    = ms;
    mem_load     = ml;
    jump_code    = jc;
    branch_taken = bt;
    illegal      = il;
  endtask

  // Entered and left just after a rising edge; ready inputs come from bit i of imr/dmr in cycle i.
  task automatic run_seq(input int n, input logic [31:0] imr, input logic [31:0] dmr);
    for (int i = 0; i < n; i++) begin
      bus.imem_ready = imr[i];
      bus.dmem_ready = dmr[i];
      @(negedge clk);
      got[i]    = obs();
      got_ir[i] = instret;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    set_dec(1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs() !== e_idle(3'd0)) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", obs(), e_idle(3'd0));
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_err++;
      $display("FAIL reset_instret: got %h want 0", instret);
    end
    n_cmp++;
    if (pc_init !== 32'h0000_1000) begin
      n_err++;
      $display("FAIL reset_pc_init: got %h want 00001000", pc_init);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_alu();
    set_dec(1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    run_seq(5, 32'h0000_000F, 32'h0);
    exp_v[0] = e_fetch(1'b1);
    exp_v[1] = e_idle(3'd1);
    exp_v[2] = e_idle(3'd2);
    exp_v[3] = e_wb(2'b00, 1'b1, 2'b00);
    exp_v[4] = e_fetch(1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin
        n_err++;
        $display("FAIL addi cycle %0d: got %b want %b", i, got[i], exp_v[i]);
      end
    end
    n_cmp++;
    if (got_ir[3] !== exp_instret) begin
      n_err++;
      $display("FAIL addi instret_before: got %0d want %0d", got_ir[3], exp_instret);
    end
    exp_instret++;
    n_cmp++;
    if (got_ir[4] !== exp_instret) begin
      n_err++;
      $display("FAIL addi instret_after: got %0d want %0d", got_ir[4], exp_instret);
    end
  endtask

  task automatic test_load();
    set_dec(1'b1, 2'b00, 3'b011, 2'b00, 1'b0, 1'b0);
    // dmem_ready is also high in F/D/E, where it must be ignored.
    run_seq(9, 32'h0000_0001, 32'h0000_01C7);
    exp_v[0] = e_fetch(1'b1);
    exp_v[1] = e_idle(3'd1);
    exp_v[2] = e_idle(3'd2);
    for (int i = 3; i < 7; i++) exp_v[i] = e_mem(1'b0, 2'b01);
    exp_v[7] = e_wb(2'b00, 1'b1, 2'b01);
    exp_v[8] = e_fetch(1'b0);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin
        n_err++;
        $display("FAIL lw cycle %0d: got %b want %b", i, got[i], exp_v[i]);
      end
    end
    exp_instret++;
    n_cmp++;
    if (got_ir[8] !== exp_instret) begin
      n_err++;
      $display("FAIL lw instret: got %0d want %0d", got_ir[8], exp_instret);
    end
  endtask

  task automatic test_store();
    logic       rw_t[2] = '{1'b0, 1'b1};
    logic [1:0] ms_t[2] = '{2'b11, 2'b01};
    for (int k = 0; k < 2; k++) begin
      set_dec(rw_t[k], ms_t[k], 3'b000, 2'b00, 1'b0, 1'b0);
      run_seq(6, 32'h0000_0001, 32'h0000_0008);
      exp_v[0] = e_fetch(1'b1);
      exp_v[1] = e_idle(3'd1);
      exp_v[2] = e_idle(3'd2);
      exp_v[3] = e_mem(1'b1, 2'b00);
      exp_v[4] = e_wb(2'b00, 1'b0, 2'b00);
      exp_v[5] = e_fetch(1'b0);
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (got[i] !== exp_v[i]) begin
          n_err++;
          $display("FAIL store%0d cycle %0d: got %b want %b", k, i, got[i], exp_v[i]);
        end
      end
      exp_instret++;
      n_cmp++;
      if (got_ir[5] !== exp_instret) begin
        n_err++;
        $display("FAIL store%0d instret: got %0d want %0d", k, got_ir[5], exp_instret);
      end
    end
  endtask

  task automatic test_branch_jump();
    // BEQ taken, BEQ not taken, JAL, JALR
    logic [1:0] jc_t[4] = '{2'b01, 2'b01, 2'b10, 2'b11};
    logic       bt_t[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       rw_t[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] ps_t[4] = '{2'b01, 2'b00, 2'b01, 2'b10};
    logic [1:0] ws_t[4] = '{2'b00, 2'b00, 2'b10, 2'b10};
    for (int k = 0; k < 4; k++) begin
      set_dec(rw_t[k], 2'b00, 3'b000, jc_t[k], bt_t[k], 1'b0);
      run_seq(5, 32'h0000_000F, 32'h0);
      exp_v[0] = e_fetch(1'b1);
      exp_v[1] = e_idle(3'd1);
      exp_v[2] = e_idle(3'd2);
      exp_v[3] = e_wb(ps_t[k], rw_t[k], ws_t[k]);
      exp_v[4] = e_fetch(1'b0);
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (got[i] !== exp_v[i]) begin
          n_err++;
          $display("FAIL jump%0d cycle %0d: got %b want %b", k, i, got[i], exp_v[i]);
        end
      end
      exp_instret++;
    end
    n_cmp++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL jump instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_illegal();
    set_dec(1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1);
    run_seq(4, 32'h0000_000D, 32'h0000_000C);
    exp_v[0] = e_fetch(1'b1);
    exp_v[1] = e_idle(3'd1);
    exp_v[2] = e_halt();
    exp_v[3] = e_halt();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin
        n_err++;
        $display("FAIL illegal cycle %0d: got %b want %b", i, got[i], exp_v[i]);
      end
    end
    n_cmp++;
    if (got_ir[3] !== exp_instret) begin
      n_err++;
      $display("FAIL illegal instret: got %0d want %0d", got_ir[3], exp_instret);
    end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    set_dec(1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    // imem_ready rises only once HALT is reached, where it must be ignored.
    run_seq(20, 32'h000F_0000, 32'h000F_0000);
    for (int i = 0; i < 16; i++) exp_v[i] = e_fetch(1'b0);
    for (int i = 16; i < 20; i++) exp_v[i] = e_halt();
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin
        n_err++;
        $display("FAIL fetch_timeout cycle %0d: got %b want %b", i, got[i], exp_v[i]);
      end
    end
    do_reset();
    run_seq(1, 32'h0, 32'h0);
    n_cmp++;
    if (got[0] !== e_fetch(1'b0)) begin
      n_err++;
      $display("FAIL halt_recover state: got %b want %b", got[0], e_fetch(1'b0));
    end
    n_cmp++;
    if (got_ir[0] !== 32'd0) begin
      n_err++;
      $display("FAIL halt_recover instret: got %0d want 0", got_ir[0]);
    end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    set_dec(1'b1, 2'b00, 3'b011, 2'b00, 1'b0, 1'b0);
    // Three FETCH wait cycles first: the watchdog must restart when MEM is entered.
    run_seq(24, 32'h0000_0008, 32'h0);
    for (int i = 0; i < 3; i++) exp_v[i] = e_fetch(1'b0);
    exp_v[3] = e_fetch(1'b1);
    exp_v[4] = e_idle(3'd1);
    exp_v[5] = e_idle(3'd2);
    for (int i = 6; i < 22; i++) exp_v[i] = e_mem(1'b0, 2'b01);
    exp_v[22] = e_halt();
    exp_v[23] = e_halt();
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (got[i] !== exp_v[i]) begin
        n_err++;
        $display("FAIL mem_timeout cycle %0d: got %b want %b", i, got[i], exp_v[i]);
      end
    end
    n_cmp++;
    if (got_ir[23] !== 32'd0) begin
      n_err++;
      $display("FAIL mem_timeout instret: got %0d want 0", got_ir[23]);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    set_dec(1'b0, 2'b11, 3'b000, 2'b00, 1'b0, 1'b0);
    run_seq(4, 32'h0000_0001, 32'h0);
    n_cmp++;
    if (got[3] !== e_mem(1'b1, 2'b00)) begin
      n_err++;
      $display("FAIL mid_mem before: got %b want %b", got[3], e_mem(1'b1, 2'b00));
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.dmem_req, bus.dmem_we, bus.imem_req} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_mem drop: got req/we/ireq %b want 000", {bus.dmem_req, bus.dmem_we, bus.imem_req});
    end
    n_cmp++;
    if ({dut_state, pc_we, rf_we} !== 5'b00000) begin
      n_err++;
      $display("FAIL mid_mem state: got state/pc_we/rf_we %b want 00000", {dut_state, pc_we, rf_we});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_seq(1, 32'h0, 32'h0);
    n_cmp++;
    if (got[0] !== e_fetch(1'b0)) begin
      n_err++;
      $display("FAIL mid_mem after: got %b want %b", got[0], e_fetch(1'b0));
    end
    n_cmp++;
    if (got_ir[0] !== 32'd0) begin
      n_err++;
      $display("FAIL mid_mem instret: got %0d want 0", got_ir[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    set_dec(1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch_jump();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
